fp_exp_align_swap: RTL and testbench
====================================

# fp_exp_align_swap

Exponent-compare and operand-swap front end of the floating-point adder datapath. Takes the biased exponents and 23-bit fractions of two single-precision operands. Produces four results, registered one cycle later:
- the exponent difference and borrow,
- the larger (result) exponent,
- the right-shift amount for the smaller operand,
- the fraction pair reordered so the larger-exponent operand is first.

It sits between operand unpack and the alignment shifter.

## Interface
Parameters:
- EXP_W, 8, exponent width (biased).
- SIG_W, 23, fraction width (hidden bit not included).
- SHIFT_SAT, 26, shift threshold at or above which the smaller operand is fully shifted out of the guard/round/sticky field.

Ports:
- clk  input  1  rising-edge clock, the block's only clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands valid this cycle.
- exp1  input  EXP_W  biased exponent, operand 1.
- exp2  input  EXP_W  biased exponent, operand 2.
- sig1  input  SIG_W  fraction, operand 1.
- sig2  input  SIG_W  fraction, operand 2.
- out_valid  output  1  registered results valid.
- diff  output  EXP_W  exp1 − exp2, modulo 2^EXP_W (raw two's-complement difference).
- borrow  output  1  1 when exp1 < exp2 (unsigned compare).
- exp_r  output  EXP_W  max(exp1, exp2).
- swap  output  1  operands exchanged; equals borrow.
- shift  output  EXP_W  |exp1 − exp2|, the right-shift amount for the smaller operand.
- shift_sat  output  1  1 when shift ≥ SHIFT_SAT.
- sig1_swap  output  SIG_W  fraction of the larger-exponent operand.
- sig2_swap  output  SIG_W  fraction of the smaller-exponent operand, which is the one to be shifted.

## Operation
- Compare stage (combinational):
  - Compute {borrow, diff} as a (EXP_W+1)-bit subtraction exp1 − exp2.
  - borrow is the inverted carry-out of that subtraction.
  - exp_r = borrow ? exp2 : exp1.
- Swap stage (combinational, driven from the compare stage):
  - swap = borrow.
  - shift = borrow ? (~diff + 1) : diff. This is the two's-complement negate, truncated to EXP_W.
  - sig1_swap = borrow ? sig2 : sig1.
  - sig2_swap = borrow ? sig1 : sig2.
  - shift_sat = (shift ≥ SHIFT_SAT).
- Equal exponents: borrow = 0, swap = 0, shift = 0, and the fractions pass through unchanged. No fraction-magnitude comparison is made; ordering is decided by exponent only.
- Zero or denormal exponents (exp = 0) are treated as the plain value 0. There is no special handling for denormals, NaN or infinity (exp = 255); these are handled downstream.
- All outputs are loaded from the combinational results only when in_valid = 1. When in_valid = 0, the data outputs hold their previous values.

## Timing
- Latency is 1 cycle. Inputs sampled on rising clk edge N with in_valid = 1 appear on the outputs after edge N, and out_valid = 1 in that cycle.
- Throughput is one operand pair per cycle. There is no backpressure.
- out_valid is registered as in_valid on every edge, so it is a 1-cycle pulse per accepted input.
- Reset:
  - rst_n low immediately (asynchronously) clears all registered outputs to 0: out_valid, diff, borrow, exp_r, swap, shift, shift_sat, sig1_swap, sig2_swap.
  - Reset asserted during operation discards any in-flight result.
  - The first valid input after rst_n deasserts produces out_valid on the following edge.
- Back-to-back valid inputs produce back-to-back results with no bubble.

## Test plan
- exp1 = 127, exp2 = 122 (1.0 vs 0.05), sig1 = 0, sig2 = 0x4CCCCD → diff = 5, borrow = 0, swap = 0, shift = 5, exp_r = 127, sig1_swap = 0, sig2_swap = 0x4CCCCD.
- exp1 = 125, exp2 = 127 (0.25 vs 1.23) → diff = 254, borrow = 1, swap = 1, shift = 2, exp_r = 127, and the fractions are exchanged.
- exp1 = 0, exp2 = 117 (0 vs 0.001) → diff = 139, borrow = 1, shift = 117, shift_sat = 1, exp_r = 117.
- exp1 = exp2 = 100, sig1 = 0x000001, sig2 = 0x7FFFFF → diff = 0, borrow = 0, swap = 0, shift = 0, shift_sat = 0, no exchange.
- Boundary pair:
  - exp1 = 255, exp2 = 0 → diff = 255, borrow = 0, shift = 255.
  - Swapped (exp1 = 0, exp2 = 255) → diff = 1, borrow = 1, shift = 255.
  - exp1 = 131, exp2 = 121 → shift = 10.
  - exp1 = 26, exp2 = 0 → shift = 26, shift_sat = 1.
  - exp1 = 25, exp2 = 0 → shift = 25, shift_sat = 0.
- Control and reset:
  - Hold in_valid = 0 with changing inputs → outputs hold and out_valid = 0.
  - Assert rst_n = 0 mid-stream between clock edges → all outputs read 0 before the next edge.
  - A valid input on the first cycle after reset produces its result one cycle later.

Source files
------------

// File: rtl/fp_exp_align_swap.sv
// Exponent compare and operand swap front end of the FP adder. Orders the operand pair by
// exponent and produces the alignment shift for the smaller one, registered with one cycle of latency.
module fp_exp_align_swap #(
  parameter int unsigned EXP_W     = 8,
  parameter int unsigned SIG_W     = 23,
  parameter int unsigned SHIFT_SAT = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [EXP_W-1:0] exp1,
  input  logic [EXP_W-1:0] exp2,
  input  logic [SIG_W-1:0] sig1,
  input  logic [SIG_W-1:0] sig2,
  output logic             out_valid,
  output logic [EXP_W-1:0] diff,
  output logic             borrow,
  output logic [EXP_W-1:0] exp_r,
  output logic             swap,
  output logic [EXP_W-1:0] shift,
  output logic             shift_sat,
  output logic [SIG_W-1:0] sig1_swap,
  output logic [SIG_W-1:0] sig2_swap
);

  localparam logic [EXP_W-1:0] ExpOne = {{(EXP_W-1){1'b0}}, 1'b1};

  logic [EXP_W:0]   w_sub;
  logic [EXP_W-1:0] w_diff;
  logic             w_borrow;
  logic [EXP_W-1:0] w_exp_r;
  logic [EXP_W-1:0] w_shift;
  logic             w_shift_sat;
  logic [SIG_W-1:0] w_sig1_swap;
  logic [SIG_W-1:0] w_sig2_swap;

  logic             r_out_valid;
  logic [EXP_W-1:0] r_diff;
  logic             r_borrow;
  logic [EXP_W-1:0] r_exp_r;
  logic             r_swap;
  logic [EXP_W-1:0] r_shift;
  logic             r_shift_sat;
  logic [SIG_W-1:0] r_sig1_swap;
  logic [SIG_W-1:0] r_sig2_swap;

  // The MSB of the zero-extended difference is the inverted carry-out, i.e. the borrow.
  always_comb begin
    w_sub       = {1'b0, exp1} - {1'b0, exp2};
    w_diff      = w_sub[EXP_W-1:0];
    w_borrow    = w_sub[EXP_W];
    w_exp_r     = w_borrow ? exp2 : exp1;
    w_shift     = w_borrow ? (~w_diff + ExpOne) : w_diff;
    w_shift_sat = ({{(32-EXP_W){1'b0}}, w_shift} >= SHIFT_SAT);
    w_sig1_swap = w_borrow ? sig2 : sig1;
    w_sig2_swap = w_borrow ? sig1 : sig2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_diff      <= '0;
      r_borrow    <= 1'b0;
      r_exp_r     <= '0;
      r_swap      <= 1'b0;
      r_shift     <= '0;
      r_shift_sat <= 1'b0;
      r_sig1_swap <= '0;
      r_sig2_swap <= '0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_diff      <= w_diff;
        r_borrow    <= w_borrow;
        r_exp_r     <= w_exp_r;
        r_swap      <= w_borrow;
        r_shift     <= w_shift;
        r_shift_sat <= w_shift_sat;
        r_sig1_swap <= w_sig1_swap;
        r_sig2_swap <= w_sig2_swap;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign borrow    = r_borrow;
  assign exp_r     = r_exp_r;
  assign swap      = r_swap;
  assign shift     = r_shift;
  assign shift_sat = r_shift_sat;
  assign sig1_swap = r_sig1_swap;
  assign sig2_swap = r_sig2_swap;

endmodule

// File: tb/tb_fp_exp_align_swap.sv
// Self-checking bench for fp_exp_align_swap: directed vector table, control/reset sequences,
// and randomized traffic against an arithmetic reference model.
module tb_fp_exp_align_swap;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  exp1, exp2;
  logic [22:0] sig1, sig2;
  logic        out_valid;
  logic [7:0]  diff;
  logic        borrow;
  logic [7:0]  exp_r;
  logic        swap;
  logic [7:0]  shift;
  logic        shift_sat;
  logic [22:0] sig1_swap, sig2_swap;

  int checks   = 0;
  int failures = 0;

  fp_exp_align_swap #(
    .EXP_W    (8),
    .SIG_W    (23),
    .SHIFT_SAT(26)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .exp1     (exp1),
    .exp2     (exp2),
    .sig1     (sig1),
    .sig2     (sig2),
    .out_valid(out_valid),
    .diff     (diff),
    .borrow   (borrow),
    .exp_r    (exp_r),
    .swap     (swap),
    .shift    (shift),
    .shift_sat(shift_sat),
    .sig1_swap(sig1_swap),
    .sig2_swap(sig2_swap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  e1, e2;
    logic [22:0] s1, s2;
    logic [7:0]  diff;
    logic        borrow;
    logic [7:0]  exp_r;
    logic [7:0]  shift;
    logic        sat;
    logic [22:0] s1sw, s2sw;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] e1, input logic [7:0] e2,
                              input logic [22:0] s1, input logic [22:0] s2,
                              input logic [7:0] d, input logic b, input logic [7:0] er,
                              input logic [7:0] sh, input logic sat,
                              input logic [22:0] s1sw, input logic [22:0] s2sw);
    vec_t v;
    v.e1 = e1; v.e2 = e2; v.s1 = s1; v.s2 = s2;
    v.diff = d; v.borrow = b; v.exp_r = er; v.shift = sh; v.sat = sat;
    v.s1sw = s1sw; v.s2sw = s2sw;
    return v;
  endfunction

  // Reference: plain integer arithmetic on the unsigned exponent values.
  function automatic vec_t model(input logic [7:0] e1, input logic [7:0] e2,
                                 input logic [22:0] s1, input logic [22:0] s2);
    vec_t v;
    int a, b, d;
    a = int'(e1);
    b = int'(e2);
    d = (a > b) ? a - b : b - a;
    v.e1 = e1; v.e2 = e2; v.s1 = s1; v.s2 = s2;
    v.diff   = 8'((a - b + 256) % 256);
    v.borrow = (a < b);
    v.exp_r  = 8'((a > b) ? a : b);
    v.shift  = 8'(d);
    v.sat    = (d >= 26);
    v.s1sw   = (a < b) ? s2 : s1;
    v.s2sw   = (a < b) ? s1 : s2;
    return v;
  endfunction

  vec_t zero_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v, input logic valid);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(valid));
    chk({tag, ".diff"},      32'(diff),      32'(v.diff));
    chk({tag, ".borrow"},    32'(borrow),    32'(v.borrow));
    chk({tag, ".exp_r"},     32'(exp_r),     32'(v.exp_r));
    chk({tag, ".swap"},      32'(swap),      32'(v.borrow));
    chk({tag, ".shift"},     32'(shift),     32'(v.shift));
    chk({tag, ".shift_sat"}, 32'(shift_sat), 32'(v.sat));
    chk({tag, ".sig1_swap"}, 32'(sig1_swap), 32'(v.s1sw));
    chk({tag, ".sig2_swap"}, 32'(sig2_swap), 32'(v.s2sw));
  endtask

  task automatic drive(input logic v, input logic [7:0] e1, input logic [7:0] e2,
                       input logic [22:0] s1, input logic [22:0] s2);
    @(negedge clk);
    in_valid = v; exp1 = e1; exp2 = e2; sig1 = s1; sig2 = s2;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[10];
  vec_t last;
  vec_t cur;

  initial begin
    zero_v = mk(8'd0, 8'd0, 23'd0, 23'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0, 23'd0, 23'd0);
    tbl[0] = mk(8'd127, 8'd122, 23'h000000, 23'h4CCCCD,
                8'd5, 1'b0, 8'd127, 8'd5, 1'b0, 23'h000000, 23'h4CCCCD);
    tbl[1] = mk(8'd125, 8'd127, 23'h000000, 23'h1D70A4,
                8'd254, 1'b1, 8'd127, 8'd2, 1'b0, 23'h1D70A4, 23'h000000);
    tbl[2] = mk(8'd0, 8'd117, 23'h000000, 23'h03126F,
                8'd139, 1'b1, 8'd117, 8'd117, 1'b1, 23'h03126F, 23'h000000);
    tbl[3] = mk(8'd100, 8'd100, 23'h000001, 23'h7FFFFF,
                8'd0, 1'b0, 8'd100, 8'd0, 1'b0, 23'h000001, 23'h7FFFFF);
    tbl[4] = mk(8'd255, 8'd0, 23'h123456, 23'h654321,
                8'd255, 1'b0, 8'd255, 8'd255, 1'b1, 23'h123456, 23'h654321);
    tbl[5] = mk(8'd0, 8'd255, 23'h123456, 23'h654321,
                8'd1, 1'b1, 8'd255, 8'd255, 1'b1, 23'h654321, 23'h123456);
    tbl[6] = mk(8'd131, 8'd121, 23'h0ABCDE, 23'h111111,
                8'd10, 1'b0, 8'd131, 8'd10, 1'b0, 23'h0ABCDE, 23'h111111);
    tbl[7] = mk(8'd26, 8'd0, 23'h222222, 23'h333333,
                8'd26, 1'b0, 8'd26, 8'd26, 1'b1, 23'h222222, 23'h333333);
    tbl[8] = mk(8'd25, 8'd0, 23'h444444, 23'h555555,
                8'd25, 1'b0, 8'd25, 8'd25, 1'b0, 23'h444444, 23'h555555);
    tbl[9] = mk(8'd0, 8'd26, 23'h666666, 23'h777777,
                8'd230, 1'b1, 8'd26, 8'd26, 1'b1, 23'h777777, 23'h666666);

    rst_n = 1'b0; in_valid = 1'b0;
    exp1 = 8'd0; exp2 = 8'd0; sig1 = 23'd0; sig2 = 23'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", zero_v, 1'b0);

    // First valid cycle right after reset release.
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, tbl[0].e1, tbl[0].e2, tbl[0].s1, tbl[0].s2);
    chk_all("first_after_reset", tbl[0], 1'b1);

    // Back-to-back directed vectors.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, tbl[i].e1, tbl[i].e2, tbl[i].s1, tbl[i].s2);
      chk_all($sformatf("vec%0d", i), tbl[i], 1'b1);
    end

    // in_valid low with changing inputs: data holds, out_valid drops.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'(10 + 40 * i), 8'(200 - 30 * i), 23'(32'h1000 * (i + 1)), 23'h7F0F0F);
      chk_all($sformatf("hold%0d", i), tbl[9], 1'b0);
    end

    // Reset between edges clears everything before the next edge.
    drive(1'b1, tbl[1].e1, tbl[1].e2, tbl[1].s1, tbl[1].s2);
    chk_all("pre_midreset", tbl[1], 1'b1);
    @(negedge clk);
    in_valid = 1'b1;
    exp1 = tbl[2].e1; exp2 = tbl[2].e2; sig1 = tbl[2].s1; sig2 = tbl[2].s2;
    #1;
    rst_n = 1'b0;
    #1;
    chk_all("midreset", zero_v, 1'b0);
    @(posedge clk);
    #1;
    chk_all("midreset_held", zero_v, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    drive(1'b1, tbl[5].e1, tbl[5].e2, tbl[5].s1, tbl[5].s2);
    chk_all("after_midreset", tbl[5], 1'b1);

    // Randomized traffic against the reference model.
    last = tbl[5];
    for (int i = 0; i < 300; i++) begin
      logic        v;
      logic [7:0]  e1, e2;
      logic [22:0] s1, s2;
      v  = ($urandom_range(0, 3) != 0);
      e1 = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       e2 = e1;
        1:       e2 = 8'(int'(e1) + $urandom_range(0, 60) - 30);
        default: e2 = 8'($urandom);
      endcase
      s1 = 23'($urandom);
      s2 = 23'($urandom);
      if (v) last = model(e1, e2, s1, s2);
      drive(v, e1, e2, s1, s2);
      cur = last;
      chk_all($sformatf("rand%0d", i), cur, v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
